instr_queue_reg: RTL

Parametrised successor to the single-entry instruction register: a small in-order queue of fetched instructions that splits each entry into opcode and register-address/immediate fields and presents the oldest entry to the decoder via a valid/take handshake. It sits between instruction memory and the control unit. It absorbs fetch/decode rate mismatch, supports pipeline flush on branches, and flags dropped fetches.

---
 rtl/instr_queue_reg_pkg.sv | 25 ++
 rtl/iqr_ptr.sv | 33 +++
 rtl/instr_queue_reg.sv | 114 +++++++++++
 3 files changed

// File: rtl/instr_queue_reg_pkg.sv
// Shared definitions for the instruction queue and the control unit:
// default field widths, the opcode enumeration, and a count-width helper.
package instr_queue_reg_pkg;

    localparam int OPC_W_DEF = 4;
    localparam int OPR_W_DEF = 4;

    // Opcode values as decoded by the control unit
    typedef enum logic [OPC_W_DEF-1:0] {
        OP_NOP = 4'h0,
        OP_LDA = 4'h1,
        OP_ADD = 4'h2,
        OP_SUB = 4'h3,
        OP_STA = 4'h4,
        OP_JMP = 4'h5,
        OP_JZ  = 4'h6,
        OP_HLT = 4'hF
    } opcode_e;

    // Bits needed to hold an occupancy value in 0..depth
    function automatic int iqr_cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/iqr_ptr.sv
// Modulo-DEPTH queue pointer with increment enable and synchronous clear.
module iqr_ptr #(
    parameter int DEPTH = 2,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             clb,
    input  logic             clr_i,
    input  logic             inc_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_d, ptr_q;

    // Next pointer: clear wins, otherwise wrap at DEPTH-1
    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = (ptr_q == PTR_W'(DEPTH - 1)) ? '0 : ptr_q + PTR_W'(1);
        end
    end

    // Pointer register
    always_ff @(posedge clk or negedge clb) begin
        if (!clb) ptr_q <= '0;
        else      ptr_q <= ptr_d;
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/instr_queue_reg.sv
// In-order instruction queue between instruction memory and the control unit.
// Head entry is split into opcode/operand fields behind a valid/take handshake.
// Optional feature macro: IQR_SIGN_EXT_EN adds imm_sext_o (sign-extended operand).
module instr_queue_reg
    import instr_queue_reg_pkg::*;
#(
    parameter int OPC_W = OPC_W_DEF,
    parameter int OPR_W = OPR_W_DEF,
    parameter int DEPTH = 2,
    parameter int EXT_W = 8
) (
    input  logic                         clk,
    input  logic                         clb,
    input  logic                         load_i,
    input  logic [OPC_W+OPR_W-1:0]       instr_i,
    output logic                         ready_o,
    input  logic                         flush_i,
    input  logic                         take_i,
    output logic                         valid_o,
    output logic [OPC_W-1:0]             opcode_o,
    output logic [OPR_W-1:0]             operand_o,
    output logic [iqr_cnt_w(DEPTH)-1:0]  count_o,
    output logic                         drop_o
`ifdef IQR_SIGN_EXT_EN
    ,
    output logic [EXT_W-1:0]             imm_sext_o
`endif
);

    localparam int INSTR_W = OPC_W + OPR_W;
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int CNT_W   = iqr_cnt_w(DEPTH);

    // Parameter legality, caught at elaboration
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
        $error("instr_queue_reg: DEPTH must be a power of two >= 2");
    end
    if (EXT_W < OPR_W) begin : g_bad_ext
        $error("instr_queue_reg: EXT_W must be >= OPR_W");
    end

    logic [DEPTH-1:0][INSTR_W-1:0] mem_d, mem_q;
    logic [CNT_W-1:0]              count_d, count_q;
    logic                          drop_d, drop_q;
    logic [PTR_W-1:0]              wptr, rptr;
    logic                          load_acc, take_acc;
    logic [INSTR_W-1:0]            head;

    // Handshake flags come from registered count only
    assign ready_o  = (count_q != CNT_W'(DEPTH));
    assign valid_o  = (count_q != '0);
    assign load_acc = load_i & ready_o & ~flush_i;
    assign take_acc = take_i & valid_o & ~flush_i;

    iqr_ptr #(.DEPTH(DEPTH)) u_wptr (
        .clk   (clk),
        .clb   (clb),
        .clr_i (flush_i),
        .inc_i (load_acc),
        .ptr_o (wptr)
    );

    iqr_ptr #(.DEPTH(DEPTH)) u_rptr (
        .clk   (clk),
        .clb   (clb),
        .clr_i (flush_i),
        .inc_i (take_acc),
        .ptr_o (rptr)
    );

    // Next storage, occupancy and sticky drop flag; flush overrides everything
    always_comb begin
        mem_d   = mem_q;
        count_d = count_q;
        drop_d  = drop_q;
        if (flush_i) begin
            count_d = '0;
            drop_d  = 1'b0;
        end else begin
            if (load_acc) mem_d[wptr] = instr_i;
            count_d = count_q + CNT_W'(load_acc) - CNT_W'(take_acc);
            if (load_i && !ready_o) drop_d = 1'b1;
        end
    end

    // Storage carries no reset; only entries behind valid count are visible
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Control state
    always_ff @(posedge clk or negedge clb) begin
        if (!clb) begin
            count_q <= '0;
            drop_q  <= 1'b0;
        end else begin
            count_q <= count_d;
            drop_q  <= drop_d;
        end
    end

    // Head fields, forced to zero while empty
    assign head      = valid_o ? mem_q[rptr] : '0;
    assign opcode_o  = head[INSTR_W-1:OPR_W];
    assign operand_o = head[OPR_W-1:0];
    assign count_o   = count_q;
    assign drop_o    = drop_q;

`ifdef IQR_SIGN_EXT_EN
    // operand_o is already zero when empty, so the extension is too
    assign imm_sext_o = EXT_W'($signed(operand_o));
`endif

endmodule
